// File: rtl/pipe_pkg.sv
// Shared types, defaults and LFSR tap masks for the pipe-column generator.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_PIPE
    } pipe_state_t;

    localparam int DEF_ROWS     = 8;
    localparam int DEF_GAP      = 2;
    localparam int DEF_SPACING  = 2;
    localparam int DEF_MAX_STEP = 1;
    localparam int DEF_LFSR_W   = 8;

    // Bit k set means register bit k feeds the XOR (maximal-length polys).
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] m;
        m = 16'h0000;
        case (width)
            3:  m = 16'h0006;
            4:  m = 16'h000C;
            5:  m = 16'h0014;
            6:  m = 16'h0030;
            7:  m = 16'h0060;
            8:  m = 16'h00B8;
            9:  m = 16'h0110;
            10: m = 16'h0240;
            11: m = 16'h0500;
            12: m = 16'h0829;
            13: m = 16'h100D;
            14: m = 16'h2015;
            15: m = 16'h6000;
            16: m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR, seed 1 on reset.
module lfsr_gen
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    output logic [W-1:0] lfsr_o
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= W'(1);
        end else begin
            lfsr_q <= {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pipe_column_gen.sv
// Pipe-column generator: blank spacers then a pipe with a random-walk gap.
// Optional gap shrinking every 8 pipes when PIPE_SHRINK_EN is defined.
module pipe_column_gen
    import pipe_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int GAP      = DEF_GAP,
    parameter int SPACING  = DEF_SPACING,
    parameter int MAX_STEP = DEF_MAX_STEP,
    parameter int LFSR_W   = DEF_LFSR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    advance,
    input  logic                    lose,
    output logic [ROWS-1:0]         pattern,
    output logic                    pipe_col,
    output logic [$clog2(ROWS)-1:0] gap_pos,
    output logic [$clog2(ROWS):0]   gap_w,
    output logic [15:0]             pipe_count
);

    localparam int PW = $clog2(ROWS);
    localparam int CW = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [PW-1:0] POS0 = PW'((ROWS - GAP) / 2);
    localparam logic [PW:0]   GW0  = (PW+1)'(GAP);
    localparam logic [CW-1:0] CLAST = CW'(SPACING - 1);

    pipe_state_t   state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [PW:0]   gw_q, gw_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [LFSR_W-1:0] lfsr;

    logic [15:0] cnt_nxt;
    logic [PW:0] gw_nxt;
    int          mag;
    int          hi;
    int          tgt;
    logic        unused_lfsr;

    lfsr_gen #(.W(LFSR_W)) u_lfsr (
        .clk_i (clk),
        .rst_ni(reset),
        .lfsr_o(lfsr)
    );

    assign unused_lfsr = ^lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            pos_q   <= POS0;
            gw_q    <= GW0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            pos_q   <= pos_d;
            gw_q    <= gw_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        pos_d   = pos_q;
        gw_d    = gw_q;
        cnt_d   = cnt_q;
        cnt_nxt = cnt_q + 16'd1;
        gw_nxt  = gw_q;
`ifdef PIPE_SHRINK_EN
        if (cnt_nxt[2:0] == 3'd0 && gw_q > (PW+1)'(1)) begin
            gw_nxt = gw_q - (PW+1)'(1);
        end
`endif
        // Clamp against the width that will apply to the next pipe.
        mag = 1 + (int'(lfsr[2:1]) % MAX_STEP);
        hi  = ROWS - int'(gw_nxt) - 1;
        tgt = lfsr[0] ? int'(pos_q) + mag : int'(pos_q) - mag;
        if (tgt < 1) begin
            tgt = 1;
        end else if (tgt > hi) begin
            tgt = hi;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start && !lose) begin
                    state_d = S_GAP;
                    col_d   = '0;
                end
            end
            S_GAP: begin
                if (advance && !lose) begin
                    if (col_q == CLAST) begin
                        state_d = S_PIPE;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_PIPE: begin
                if (advance && !lose) begin
                    state_d = S_GAP;
                    col_d   = '0;
                    pos_d   = PW'(tgt);
                    gw_d    = gw_nxt;
                    cnt_d   = cnt_nxt;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pattern = '0;
        if (state_q == S_PIPE) begin
            for (int i = 0; i < ROWS; i++) begin
                pattern[i] = !((i >= int'(pos_q)) &&
                               (i < int'(pos_q) + int'(gw_q)));
            end
        end
    end

    assign pipe_col   = (state_q == S_PIPE);
    assign gap_pos    = pos_q;
    assign gap_w      = gw_q;
    assign pipe_count = cnt_q;

endmodule
